// File: rtl/obstacle_height_scheduler.sv
// obstacle_height_scheduler
// Round-robin arbiter that hands out one shared LFSR draw per obstacle slot,
// maps the draw into the playable height band, slew-limits it against the
// previously issued height and stores it in a per-slot height table.

module obstacle_height_scheduler #(
    parameter int N_SLOTS  = 4,
    parameter int START_Y  = 200,
    parameter int Y_MIN    = 65,
    parameter int Y_RANGE  = 400,
    parameter int MAX_STEP = 150
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pause,
    input  logic [N_SLOTS-1:0]      req,
    output logic [N_SLOTS-1:0]      ack,
    output logic                    lfsr_gen,
    input  logic [29:0]             lfsr_data,
    output logic [10*N_SLOTS-1:0]   y_table,
    output logic [9:0]              last_y,
    output logic                    busy
);

    localparam int IDX_W    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int N_STAGES = (1024 + Y_RANGE - 1) / Y_RANGE;

    localparam logic [10:0]        Y_RANGE_W  = 11'(Y_RANGE);
    localparam logic [10:0]        Y_MIN_W    = 11'(Y_MIN);
    localparam logic signed [10:0] MAX_STEP_S = 11'(MAX_STEP);
    localparam logic [9:0]         START_Y_W  = 10'(START_Y);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        SAMPLE = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [9:0]       r_q, r_d;
    logic [9:0]       last_y_q, last_y_d;
    logic [9:0]       y_table_q [N_SLOTS];
    logic [9:0]       y_table_d [N_SLOTS];

    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic [10:0]      mapped;
    logic [9:0]       new_y;
    logic             lfsr_unused;

    // Only the low 10 bits of the LFSR word feed the height mapping.
    assign lfsr_unused = ^lfsr_data[29:10];

    // Round-robin search: first set request at or above rr_ptr, wrapping around.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        arb_idx   = rr_ptr_q;
        arb_found = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= N_SLOTS) begin
                cand = cand - N_SLOTS;
            end
            cand_idx = IDX_W'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Range reduction r mod Y_RANGE by unrolled conditional subtraction.
    always_comb begin
        mapped = {1'b0, r_q};
        for (int s = 0; s < N_STAGES; s++) begin
            if (mapped >= Y_RANGE_W) begin
                mapped = mapped - Y_RANGE_W;
            end
        end
    end

    // Slew clamp in signed arithmetic so last_y - MAX_STEP may go negative safely.
    always_comb begin
        logic signed [10:0] target_s;
        logic signed [10:0] last_s;
        logic signed [10:0] hi_s;
        logic signed [10:0] lo_s;
        logic signed [10:0] clamp_s;
        target_s = $signed(mapped + Y_MIN_W);
        last_s   = $signed({1'b0, last_y_q});
        hi_s     = last_s + MAX_STEP_S;
        lo_s     = last_s - MAX_STEP_S;
        if (target_s > hi_s) begin
            clamp_s = hi_s;
        end else if (target_s < lo_s) begin
            clamp_s = lo_s;
        end else begin
            clamp_s = target_s;
        end
        new_y = clamp_s[9:0];
    end

    // Next-state logic: grant in IDLE, pulse gen in DRAW, capture in SAMPLE, write in COMMIT.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        r_d       = r_q;
        last_y_d  = last_y_q;
        y_table_d = y_table_q;
        case (state_q)
            IDLE: begin
                if (!pause && arb_found) begin
                    gnt_idx_d = arb_idx;
                    state_d   = DRAW;
                end
            end
            DRAW: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                r_d     = lfsr_data[9:0];
                state_d = COMMIT;
            end
            COMMIT: begin
                y_table_d[gnt_idx_q] = new_y;
                last_y_d             = new_y;
                rr_ptr_d             = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
                state_d              = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all returning to their start values on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            r_q       <= '0;
            last_y_q  <= START_Y_W;
            for (int k = 0; k < N_SLOTS; k++) begin
                y_table_q[k] <= START_Y_W;
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            r_q       <= r_d;
            last_y_q  <= last_y_d;
            for (int k = 0; k < N_SLOTS; k++) begin
                y_table_q[k] <= y_table_d[k];
            end
        end
    end

    // Decoded outputs: ack marks the slot being written this cycle.
    always_comb begin
        ack = '0;
        if (state_q == COMMIT) begin
            ack[gnt_idx_q] = 1'b1;
        end
        lfsr_gen = (state_q == DRAW);
        busy     = (state_q != IDLE);
        last_y   = last_y_q;
        for (int k = 0; k < N_SLOTS; k++) begin
            y_table[10*k +: 10] = y_table_q[k];
        end
    end

endmodule

// File: tb/tb_obstacle_height_scheduler.sv
// tb_obstacle_height_scheduler
// Directed vectors with hand-computed heights for the default parameter set.

module tb_obstacle_height_scheduler;

    logic        clk;
    logic        reset_n;
    logic        pause;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        lfsr_gen;
    logic [29:0] lfsr_data;
    logic [39:0] y_table;
    logic [9:0]  last_y;
    logic        busy;

    int vecCount  = 0;
    int missCount = 0;

    obstacle_height_scheduler #(
        .N_SLOTS (4),
        .START_Y (200),
        .Y_MIN   (65),
        .Y_RANGE (400),
        .MAX_STEP(150)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pause    (pause),
        .req      (req),
        .ack      (ack),
        .lfsr_gen (lfsr_gen),
        .lfsr_data(lfsr_data),
        .y_table  (y_table),
        .last_y   (last_y),
        .busy     (busy)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive the block inputs; upper LFSR bits carry junk that must be ignored.
    task automatic applyStimulus(input logic [3:0] reqV, input logic pauseV, input logic [9:0] rData);
        req       = reqV;
        pause     = pauseV;
        lfsr_data = {20'hABCDE, rData};
    endtask

    function automatic logic [9:0] slotY(input int k);
        return y_table[10*k +: 10];
    endfunction

    // One full grant from IDLE: DRAW, SAMPLE, COMMIT, then back in IDLE.
    task automatic runGrant(input string tag, input logic [3:0] reqV, input logic [9:0] rData,
                            input logic [3:0] expAck, input int slot, input logic [9:0] expY,
                            input bit keepReq);
        applyStimulus(reqV, 1'b0, rData);
        @(negedge clk);
        checkOutput({tag, "_gen"}, 32'(lfsr_gen), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_gen_off"}, 32'(lfsr_gen), 32'd0);
        checkOutput({tag, "_noack"}, 32'(ack), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_ack"}, 32'(ack), 32'(expAck));
        if (!keepReq) begin
            req = 4'b0000;
        end
        @(negedge clk);
        checkOutput({tag, "_ack_done"}, 32'(ack), 32'd0);
        checkOutput({tag, "_y"}, 32'(slotY(slot)), 32'(expY));
        checkOutput({tag, "_last"}, 32'(last_y), 32'(expY));
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(4'b0000, 1'b0, 10'd0);

        // Reset values, then after release.
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rst_y%0d", k), 32'(slotY(k)), 32'd200);
        end
        checkOutput("rst_last", 32'(last_y), 32'd200);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_gen", 32'(lfsr_gen), 32'd0);
        checkOutput("rst_busy2", 32'(busy), 32'd0);

        // r=300 -> 365 clamped up to 350 on slot 1.
        runGrant("up", 4'b0010, 10'd300, 4'b0010, 1, 10'd350, 1'b0);
        // r=900 -> m=100, 165 clamped down to 200 on slot 0 (search wraps from 2).
        runGrant("down", 4'b0001, 10'd900, 4'b0001, 0, 10'd200, 1'b0);
        // r=1023 -> m=223, 288 issued unclamped on slot 3.
        runGrant("free", 4'b1000, 10'd1023, 4'b1000, 3, 10'd288, 1'b0);
        checkOutput("keep_y1", 32'(slotY(1)), 32'd350);

        // Round-robin with all requests held: slots 0,1,2,3,0 four cycles apart.
        runGrant("rr0", 4'b1111, 10'd400, 4'b0001, 0, 10'd138, 1'b1);
        runGrant("rr1", 4'b1111, 10'd400, 4'b0010, 1, 10'd65, 1'b1);
        runGrant("rr2", 4'b1111, 10'd799, 4'b0100, 2, 10'd215, 1'b1);
        runGrant("rr3", 4'b1111, 10'd0, 4'b1000, 3, 10'd65, 1'b1);
        runGrant("rr4", 4'b1111, 10'd599, 4'b0001, 0, 10'd215, 1'b0);
        checkOutput("rr_y1", 32'(slotY(1)), 32'd65);
        checkOutput("rr_y3", 32'(slotY(3)), 32'd65);

        // Pause holds off the grant entirely.
        applyStimulus(4'b0100, 1'b1, 10'd100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("pause_gen%0d", i), 32'(lfsr_gen), 32'd0);
            checkOutput($sformatf("pause_busy%0d", i), 32'(busy), 32'd0);
        end

        // Release pause, then drop the request during SAMPLE: commit still happens.
        pause = 1'b0;
        @(negedge clk);
        checkOutput("drop_gen", 32'(lfsr_gen), 32'd1);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        checkOutput("drop_ack", 32'(ack), 32'd4);
        @(negedge clk);
        checkOutput("drop_y2", 32'(slotY(2)), 32'd165);
        checkOutput("drop_last", 32'(last_y), 32'd165);

        // Reset during SAMPLE: no ack, table back to start values.
        applyStimulus(4'b0001, 1'b0, 10'd1000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_ack", 32'(ack), 32'd0);
        checkOutput("mid_last", 32'(last_y), 32'd200);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("mid_y%0d", k), 32'(slotY(k)), 32'd200);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        checkOutput("mid_ack_hold", 32'(ack), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_idle", 32'(busy), 32'd0);

        // Pointer was reset to 0, so slot 0 wins over slot 3; r=500 -> 165.
        runGrant("post", 4'b1001, 10'd500, 4'b0001, 0, 10'd165, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
